// File: rtl/nibble_cpu_core_if.sv
// nibble_cpu_core_if: shared code/data memory bus of the nibble CPU core.
//   master (core):   mem_req, mem_we, mem_space, mem_addr, mem_wdata out;
//                    mem_rdata, mem_ready in
//   slave (memory):  the mirror image
// A bus cycle completes on a clock edge where mem_req & mem_ready are both 1.
interface nibble_cpu_core_if #(
  parameter int DW  = 4,
  parameter int PCW = 10
);
  logic           mem_req;
  logic           mem_we;
  logic           mem_space;
  logic [PCW+1:0] mem_addr;
  logic [DW-1:0]  mem_wdata;
  logic [DW-1:0]  mem_rdata;
  logic           mem_ready;

  modport master (
    output mem_req, mem_we, mem_space, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_space, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/nibble_cpu_core.sv
// nibble_cpu_core: multi-cycle accumulator-style CPU with a 4-entry register
// file. Each instruction is three words (opcode, select/mode, operand) fetched
// over a shared code/data bus with a ready handshake; LD/ALU may take a data
// operand from memory, ST writes a register to memory.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         memory bus (master side)
//   halted      core has executed HLT
//   flags       {C, Z}
//   pc_o        current program counter (in instructions)
//   dbg_sel     register select for debug read
//   dbg_data    r[dbg_sel], combinational
module nibble_cpu_core #(
  parameter int DW        = 4,   // must be >= 4
  parameter int PCW       = 10,
  parameter int JMP_SHIFT = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  nibble_cpu_core_if.master        bus,
  output logic                     halted,
  output logic [1:0]               flags,
  output logic [PCW-1:0]           pc_o,
  input  logic [1:0]               dbg_sel,
  output logic [DW-1:0]            dbg_data
);

  localparam logic [5:0] S_F1    = 6'b000001;
  localparam logic [5:0] S_F2    = 6'b000010;
  localparam logic [5:0] S_F3    = 6'b000100;
  localparam logic [5:0] S_LOAD  = 6'b001000;
  localparam logic [5:0] S_STORE = 6'b010000;
  localparam logic [5:0] S_HALT  = 6'b100000;

  logic [5:0]     state_reg, state_next;
  logic [PCW-1:0] pc_reg, pc_next;
  logic [3:0]     i1_reg, i1_next;   // opcode
  logic [2:0]     i2_reg, i2_next;   // {mem_mode, sel[1:0]}
  logic [DW-1:0]  op_reg, op_next;   // operand, kept for LOAD/STORE addressing
  logic           c_reg, c_next, z_reg, z_next;
  logic [DW-1:0]  r_reg [4];

  logic           fire;
  logic [3:0]     opcode;
  logic [1:0]     sel;
  logic           mem_mode;
  logic           is_alu, is_jump, jump_taken;
  logic [PCW-1:0] pc_inc, jmp_target;
  logic [PCW+1:0] data_addr;
  logic [1:0]     phase;
  logic [DW-1:0]  operand, reg_a, alu_res;
  logic           alu_c;
  logic [DW:0]    add_w, sub_w;
  logic           wr_en;

  assign opcode   = i1_reg;
  assign sel      = i2_reg[1:0];
  assign mem_mode = i2_reg[2];
  assign fire     = bus.mem_req & bus.mem_ready;
  assign pc_inc   = pc_reg + PCW'(1);
  assign is_alu   = (opcode == 4'h0) || ((opcode >= 4'h2) && (opcode <= 4'h6));
  assign is_jump  = (opcode[3:2] == 2'b10);

  always_comb begin
    jump_taken = 1'b0;
    case (opcode[1:0])
      2'd0:    jump_taken = 1'b1;
      2'd1:    jump_taken = z_reg;
      2'd2:    jump_taken = ~z_reg;
      default: jump_taken = c_reg;
    endcase
  end

  // Jump target is the operand on the bus shifted left, zero-extended or
  // truncated to the pc width.
  for (genvar gi = 0; gi < PCW; gi++) begin : g_jmp
    if ((gi >= JMP_SHIFT) && (gi - JMP_SHIFT < DW)) begin : g_bit
      assign jmp_target[gi] = bus.mem_rdata[gi-JMP_SHIFT];
    end else begin : g_zero
      assign jmp_target[gi] = 1'b0;
    end
  end

  // Data address is the latched operand, zero-extended to the bus width.
  for (genvar gi = 0; gi < PCW + 2; gi++) begin : g_daddr
    if (gi < DW) begin : g_bit
      assign data_addr[gi] = op_reg[gi];
    end else begin : g_zero
      assign data_addr[gi] = 1'b0;
    end
  end

  // Immediate and memory operands both arrive on mem_rdata in the completing
  // cycle, so one ALU serves F3 and LOAD.
  assign operand = bus.mem_rdata;
  assign reg_a   = r_reg[sel];
  assign add_w   = {1'b0, reg_a} + {1'b0, operand};
  assign sub_w   = {1'b0, reg_a} - {1'b0, operand};  // MSB is the borrow

  always_comb begin
    alu_res = operand;
    alu_c   = c_reg;
    case (opcode)
      4'h2: begin alu_res = add_w[DW-1:0]; alu_c = add_w[DW]; end
      4'h3: begin alu_res = sub_w[DW-1:0]; alu_c = sub_w[DW]; end
      4'h4: begin alu_res = reg_a & operand; alu_c = 1'b0; end
      4'h5: begin alu_res = reg_a | operand; alu_c = 1'b0; end
      4'h6: begin alu_res = reg_a ^ operand; alu_c = 1'b0; end
      default: ;  // LD: result is the operand, carry untouched
    endcase
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    i1_next    = i1_reg;
    i2_next    = i2_reg;
    op_next    = op_reg;
    c_next     = c_reg;
    z_next     = z_reg;
    wr_en      = 1'b0;
    if (fire) begin
      case (state_reg)
        S_F1: begin
          i1_next    = bus.mem_rdata[3:0];
          state_next = S_F2;
        end
        S_F2: begin
          i2_next    = bus.mem_rdata[2:0];
          state_next = S_F3;
        end
        S_F3: begin
          op_next    = bus.mem_rdata;
          state_next = S_F1;
          pc_next    = pc_inc;
          if (is_jump) begin
            pc_next = jump_taken ? jmp_target : pc_inc;
          end else if (opcode == 4'hF) begin
            pc_next    = pc_reg;
            state_next = S_HALT;
          end else if (opcode == 4'h1) begin
            pc_next    = pc_reg;
            state_next = S_STORE;
          end else if (is_alu) begin
            if (mem_mode) begin
              pc_next    = pc_reg;
              state_next = S_LOAD;
            end else begin
              wr_en  = 1'b1;
              c_next = alu_c;
              z_next = (alu_res == '0);
            end
          end
        end
        S_LOAD: begin
          wr_en      = 1'b1;
          c_next     = alu_c;
          z_next     = (alu_res == '0);
          pc_next    = pc_inc;
          state_next = S_F1;
        end
        S_STORE: begin
          pc_next    = pc_inc;
          state_next = S_F1;
        end
        default: ;  // HALT never fires: mem_req is 0 there
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_F1;
      pc_reg    <= '0;
      i1_reg    <= '0;
      i2_reg    <= '0;
      op_reg    <= '0;
      c_reg     <= 1'b0;
      z_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      i1_reg    <= i1_next;
      i2_reg    <= i2_next;
      op_reg    <= op_next;
      c_reg     <= c_next;
      z_reg     <= z_next;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_rf
    logic [DW-1:0] q_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q_reg <= '0;
      end else if (wr_en && (sel == 2'(gi))) begin
        q_reg <= alu_res;
      end
    end
    assign r_reg[gi] = q_reg;
  end

  assign phase = (state_reg == S_F2) ? 2'd1 : (state_reg == S_F3) ? 2'd2 : 2'd0;

  // mem_req is gated by rst_n so that an asserted reset drops it at once,
  // including the reset state F1 which otherwise requests a fetch.
  assign bus.mem_req   = rst_n & (state_reg != S_HALT);
  assign bus.mem_we    = (state_reg == S_STORE);
  assign bus.mem_space = (state_reg == S_LOAD) || (state_reg == S_STORE);
  assign bus.mem_addr  = bus.mem_space ? data_addr : {pc_reg, phase};
  assign bus.mem_wdata = (state_reg == S_STORE) ? reg_a : '0;

  assign halted   = (state_reg == S_HALT);
  assign flags    = {c_reg, z_reg};
  assign pc_o     = pc_reg;
  assign dbg_data = r_reg[dbg_sel];

endmodule
